drag_reaction_timer: RTL
========================

// Module: drag_reaction_timer
// PURPOSE
//  Racer-side consumer of the drag-race tree light outputs. Watches stage light, green, red and the stage beam.
//  Measures reaction time from green onset to launch (stage-beam release) in ms; flags fouls.
//  Sits beside the tree controller in the board top; drives 4 BCD digits to hex decoders.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency
//  TICK_HZ  1000        timing resolution; prescaler terminal count = CLK_HZ/TICK_HZ - 1
//  MAX_BCD  16'h9999    saturation value of the reaction-time count
// PORTS
//  Clock     in   1   system clock, single domain
//  Rst       in   1   synchronous, active-high reset
//  SB        in   1   raw stage beam (switch); 1 = staged; asynchronous
//  SL        in   1   stage light from tree controller (synchronous)
//  G         in   1   green light from tree controller (synchronous)
//  R         in   1   red light from tree controller (synchronous)
//  Armed     out  1   racer staged, waiting for green
//  Timing    out  1   green seen, counting
//  Done      out  1   valid run complete; RtBcd holds result
//  Foul      out  1   launch before green, or red while armed
//  Overflow  out  1   count saturated at MAX_BCD
//  RtBcd     out  16  reaction time, 4 BCD digits [15:12]=thousands .. [3:0]=units, ms
//  BestBcd   out  16  best (lowest) valid reaction time, see CONFIGURATION
// BEHAVIOUR
//  Reset: state IDLE; all 1-bit outputs 0; RtBcd=0; BestBcd=16'h9999 (0 if macro off); prescaler 0.
//  SB passes 2-flop synchronizer -> SBs; SBq = SBs delayed 1; launch = SBq & ~SBs.
//  Launch pulse 3 cycles after SB pin falls. G rise = G & ~Gq.
//  FSM: IDLE, ARMED, TIMING, DONE, FOUL (one-hot outputs Armed/Timing/Done/Foul)
//  IDLE   -> ARMED  when SL & SBs. Done, Foul, Overflow clear; RtBcd unchanged.
//  ARMED  -> FOUL   on R, or launch while G low. R wins over G rise in same cycle.
//  ARMED  -> TIMING on G rise with no R; RtBcd<=0, prescaler<=0, Overflow<=0.
//  ARMED  -> TIMING -> DONE with RtBcd=0 if G rise and launch in the same cycle.
//  ARMED  -> IDLE   if SL drops while SBs still 1 (tree reset, no launch).
//  TIMING: prescaler counts every cycle. Tick at terminal count increments RtBcd (decimal carry per digit).
//  TIMING -> DONE   on launch; RtBcd freezes at value before any same-cycle tick increment.
//  TIMING -> DONE   with Overflow=1 when RtBcd reaches MAX_BCD; no further increments.
//  TIMING: R ignored once timing starts.
//  DONE/FOUL -> IDLE when ~SL & ~SBs; flags held until next IDLE->ARMED.
//  Rst mid-run: immediate return to reset values next edge regardless of state.
// CONFIGURATION
//  BEST_TIME_EN defined:
//   - on entry to DONE with Overflow=0, BestBcd <= min(BestBcd, final RtBcd).
//   - BestBcd cleared to 16'h9999 only by Rst.
//   - Fouls and overflows never update it.
//  BEST_TIME_EN undefined: no best register; BestBcd tied 16'h0000.
// STRUCTURE
//  Package drag_race_pkg:
//   - state enum localparams (IDLE..FOUL)
//   - BCD_MAX, BCD_RESET
//   - prescaler width function clog2(CLK_HZ/TICK_HZ)
//  Sub-module bcd_counter4:
//   - clear, inc, 16-bit BCD value, saturated flag at MAX_BCD
//   - used for RtBcd; comparator for BestBcd lives in the top of this block
// TESTING (bench uses CLK_HZ=10, TICK_HZ=1 -> tick every 10 cycles)
//  Stage (SL=1,SB=1), G rises, SB falls 35 ticks later -> Done=1, Foul=0, RtBcd=16'h0035.
//  Stage, SB falls with G=0 -> Foul=1, Done=0, Timing never 1, RtBcd unchanged.
//  Armed, R=1 and G rise same cycle -> Foul=1, Timing stays 0.
//  Green, no launch for 10000 ticks -> RtBcd=16'h9999, Overflow=1, Done=1.
//  Rst asserted during TIMING at count 0042 -> next edge all flags 0, RtBcd=0, state IDLE.
//  BEST_TIME_EN: runs 0120, 0085, foul, 0200 (unstage between) -> BestBcd=16'h0085; macro off -> 0.

Source files
------------

// File: rtl/drag_race_pkg.sv
// Shared types and constants for the drag-race reaction timer.
// Optional feature macro used by the top: BEST_TIME_EN (best-time register).
package drag_race_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    TIMING = 3'd2,
    DONE   = 3'd3,
    FOUL   = 3'd4
  } state_t;

  localparam logic [15:0] BCD_MAX   = 16'h9999;
  localparam logic [15:0] BCD_RESET = 16'h0000;

  // Ceiling log2, never below 1 so a divide-by-one prescaler still has a bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear and saturation at MAX_BCD.
module bcd_counter4 #(
  parameter logic [15:0] MAX_BCD = 16'h9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] value,
  output logic        sat
);

  logic [15:0] value_inc;

  // Decimal increment: ripple a carry through the four digits.
  always_comb begin
    logic carry;
    value_inc = value;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (value[4*i +: 4] == 4'd9) begin
          value_inc[4*i +: 4] = 4'd0;
        end else begin
          value_inc[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign sat = (value == MAX_BCD);

  // Count register: clear has priority, increments stop once saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 16'h0000;
    end else if (clear) begin
      value <= 16'h0000;
    end else if (inc && !sat) begin
      value <= value_inc;
    end
  end

endmodule

// File: rtl/drag_reaction_timer.sv
// Racer-side reaction timer: measures green-to-launch time in BCD ticks and
// flags fouls. Optional macro BEST_TIME_EN adds a best (lowest) time register;
// without it BestBcd is tied to zero.
module drag_reaction_timer
  import drag_race_pkg::*;
#(
  parameter int          CLK_HZ  = 50_000_000,
  parameter int          TICK_HZ = 1000,
  parameter logic [15:0] MAX_BCD = BCD_MAX
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        SB,
  input  logic        SL,
  input  logic        G,
  input  logic        R,
  output logic        Armed,
  output logic        Timing,
  output logic        Done,
  output logic        Foul,
  output logic        Overflow,
  output logic [15:0] RtBcd,
  output logic [15:0] BestBcd,
  output state_t      fsm_state
);

  localparam int             DIV = CLK_HZ / TICK_HZ;
  localparam int             PW  = clog2(DIV);
  localparam logic [PW-1:0]  TC  = PW'(DIV - 1);

  state_t        state, state_nxt;
  logic          sb_meta, sbs, sbq, gq;
  logic          launch, g_rise, tick;
  logic [PW-1:0] presc;
  logic          cnt_clear, cnt_inc, cnt_sat;
  logic [15:0]   cnt_value;
  logic          arm, to_done, to_foul, done_ovf;
  logic          done_flag, foul_flag, ovf_flag;

  // Stage beam is a raw switch: two-flop synchronizer plus one delay for edge detect.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      sb_meta <= 1'b0;
      sbs     <= 1'b0;
      sbq     <= 1'b0;
      gq      <= 1'b0;
    end else begin
      sb_meta <= SB;
      sbs     <= sb_meta;
      sbq     <= sbs;
      gq      <= G;
    end
  end

  assign launch = sbq & ~sbs;
  assign g_rise = G & ~gq;
  assign tick   = (state == TIMING) && (presc == TC);

  // Prescaler runs only while timing and restarts from zero on every run.
  always_ff @(posedge Clock) begin
    if (Rst || state != TIMING || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-transition strobes. Red beats green; a launch in the
  // same cycle as a tick freezes the count before that tick lands.
  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    arm       = 1'b0;
    to_done   = 1'b0;
    to_foul   = 1'b0;
    done_ovf  = 1'b0;
    case (state)
      IDLE: begin
        if (SL && sbs) begin
          state_nxt = ARMED;
          arm       = 1'b1;
        end
      end
      ARMED: begin
        if (R || (launch && !G)) begin
          state_nxt = FOUL;
          to_foul   = 1'b1;
        end else if (launch && G) begin
          state_nxt = DONE;
          cnt_clear = 1'b1;
          to_done   = 1'b1;
        end else if (g_rise) begin
          state_nxt = TIMING;
          cnt_clear = 1'b1;
        end else if (!SL && sbs) begin
          state_nxt = IDLE;
        end
      end
      TIMING: begin
        if (launch || cnt_sat) begin
          state_nxt = DONE;
          to_done   = 1'b1;
          done_ovf  = cnt_sat;
        end else begin
          cnt_inc = tick;
        end
      end
      DONE, FOUL: begin
        if (!SL && !sbs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result flags survive the return to IDLE and clear only when re-armed.
  always_ff @(posedge Clock) begin
    if (Rst || arm) begin
      done_flag <= 1'b0;
      foul_flag <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      if (to_done) begin
        done_flag <= 1'b1;
        ovf_flag  <= done_ovf;
      end
      if (to_foul) foul_flag <= 1'b1;
    end
  end

  bcd_counter4 #(.MAX_BCD(MAX_BCD)) u_rt_counter (
    .clk   (Clock),
    .rst   (Rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .value (cnt_value),
    .sat   (cnt_sat)
  );

`ifdef BEST_TIME_EN
  logic [15:0] best;
  logic [15:0] best_cand;
  logic        best_load;

  // A zero-time launch enters DONE while the counter is still being cleared.
  assign best_cand = (state == ARMED) ? BCD_RESET : cnt_value;
  assign best_load = to_done && !done_ovf;

  // Best time keeps the lowest valid result; only reset restores it.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      best <= BCD_MAX;
    end else if (best_load && (best_cand < best)) begin
      best <= best_cand;
    end
  end

  assign BestBcd = best;
`else
  assign BestBcd = BCD_RESET;
`endif

  assign Armed     = (state == ARMED);
  assign Timing    = (state == TIMING);
  assign Done      = done_flag;
  assign Foul      = foul_flag;
  assign Overflow  = ovf_flag;
  assign RtBcd     = cnt_value;
  assign fsm_state = state;

endmodule
